// File: rtl/nyancat_frame_loader_pkg.sv
// Shared definitions for the nyancat loader and renderer: the byte-stream
// protocol codes, the default frame geometry and the memory-port widths.
package nyancat_frame_loader_pkg;

    // Byte-stream protocol
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_PALETTE = 8'h01;
    localparam logic [7:0] CMD_FRAME   = 8'h02;

    // Default animation geometry
    localparam int unsigned DEF_NUM_FRAMES = 12;
    localparam int unsigned DEF_FRAME_W    = 64;
    localparam int unsigned DEF_FRAME_H    = 64;

    // Frame memory holds one 4-bit character index per location;
    // palette memory holds 16 RRGGBB entries.
    localparam int unsigned FM_DATA_W   = 4;
    localparam int unsigned PM_DATA_W   = 6;
    localparam int unsigned PM_ADDR_W   = 4;
    localparam int unsigned PAL_ENTRIES = 16;

endpackage

// File: rtl/nyancat_frame_loader.sv
// Byte-stream loader for the nyancat frame and palette memories.
// Stream format: A5 01 <16 palette bytes>  or  A5 02 <frame idx> <W*H/2 bytes>.
// Each frame byte carries two character indices, high nibble first.
module nyancat_frame_loader
    import nyancat_frame_loader_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int unsigned FRAME_W    = DEF_FRAME_W,
    parameter int unsigned FRAME_H    = DEF_FRAME_H
) (
    input  logic                                              px_clk,
    input  logic                                              reset,
    input  logic                                              s_valid,
    input  logic [7:0]                                        s_data,
    output logic                                              s_ready,
    output logic                                              fm_we,
    output logic [$clog2(NUM_FRAMES*FRAME_W*FRAME_H)-1:0]     fm_addr,
    output logic [FM_DATA_W-1:0]                              fm_wdata,
    output logic                                              pm_we,
    output logic [PM_ADDR_W-1:0]                              pm_addr,
    output logic [PM_DATA_W-1:0]                              pm_wdata,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              err
);

    localparam int unsigned FRAME_SIZE  = FRAME_W * FRAME_H;
    localparam int unsigned FRAME_BYTES = FRAME_SIZE / 2;
    localparam int unsigned ADDR_W      = $clog2(NUM_FRAMES * FRAME_SIZE);
    // Shared by the frame byte count and the palette entry count
    localparam int unsigned CNT_W       = $clog2(FRAME_BYTES + PAL_ENTRIES);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_FIDX   = 3'd2;
    localparam logic [2:0] ST_FRAME  = 3'd3;
    localparam logic [2:0] ST_LOWNIB = 3'd4;
    localparam logic [2:0] ST_PAL    = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           lo_q, lo_d;
    logic                 err_d, busy_d, done_d, s_ready_d;
    logic                 fm_we_d, pm_we_d;
    logic [ADDR_W-1:0]    fm_addr_d;
    logic [FM_DATA_W-1:0] fm_wdata_d;
    logic [PM_ADDR_W-1:0] pm_addr_d;
    logic [PM_DATA_W-1:0] pm_wdata_d;
    logic                 accept;

    assign accept = s_valid && s_ready;

    // Protocol decode and next values of every registered output
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        err_d      = err;
        done_d     = 1'b0;
        fm_we_d    = 1'b0;
        fm_addr_d  = fm_addr;
        fm_wdata_d = fm_wdata;
        pm_we_d    = 1'b0;
        pm_addr_d  = pm_addr;
        pm_wdata_d = pm_wdata;
        case (state_q)
            ST_IDLE: begin
                if (accept && s_data == SYNC_BYTE) begin
                    state_d = ST_CMD;
                    err_d   = 1'b0;
                end
            end
            ST_CMD: begin
                if (accept) begin
                    cnt_d = '0;
                    if (s_data == CMD_PALETTE) begin
                        state_d = ST_PAL;
                    end else if (s_data == CMD_FRAME) begin
                        state_d = ST_FIDX;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_FIDX: begin
                if (accept) begin
                    if (32'(s_data) < NUM_FRAMES) begin
                        base_d  = ADDR_W'(32'(s_data) * FRAME_SIZE);
                        cnt_d   = '0;
                        state_d = ST_FRAME;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_FRAME: begin
                // 0xA5 here is payload; no resync inside a frame
                if (accept) begin
                    fm_we_d    = 1'b1;
                    fm_addr_d  = base_q + (ADDR_W'(cnt_q) << 1);
                    fm_wdata_d = s_data[7:4];
                    lo_d       = s_data[3:0];
                    state_d    = ST_LOWNIB;
                end
            end
            ST_LOWNIB: begin
                fm_we_d    = 1'b1;
                fm_addr_d  = fm_addr + 1'b1;
                fm_wdata_d = lo_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            ST_PAL: begin
                if (accept) begin
                    pm_we_d    = 1'b1;
                    pm_addr_d  = cnt_q[PM_ADDR_W-1:0];
                    pm_wdata_d = s_data[PM_DATA_W-1:0];
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(PAL_ENTRIES - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        s_ready_d = (state_d != ST_LOWNIB);
        busy_d    = (state_d != ST_IDLE) || fm_we_d || pm_we_d;
    end

    // State and output registers; reset drops any pending low-nibble write
    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            cnt_q    <= '0;
            lo_q     <= '0;
            s_ready  <= 1'b1;
            fm_we    <= 1'b0;
            fm_addr  <= '0;
            fm_wdata <= '0;
            pm_we    <= 1'b0;
            pm_addr  <= '0;
            pm_wdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            s_ready  <= s_ready_d;
            fm_we    <= fm_we_d;
            fm_addr  <= fm_addr_d;
            fm_wdata <= fm_wdata_d;
            pm_we    <= pm_we_d;
            pm_addr  <= pm_addr_d;
            pm_wdata <= pm_wdata_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_nyancat_frame_loader.sv
// Self-checking bench for nyancat_frame_loader: directed byte streams, an
// expected-write queue built from the stream format, and a per-cycle monitor.
module tb_nyancat_frame_loader;

    localparam int NF  = 12;
    localparam int FW  = 64;
    localparam int FH  = 64;
    localparam int FSZ = FW * FH;
    localparam int FB  = FSZ / 2;

    logic        px_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_ready, fm_we, pm_we, busy, done, err;
    logic [15:0] fm_addr;
    logic [3:0]  fm_wdata;
    logic [3:0]  pm_addr;
    logic [5:0]  pm_wdata;

    nyancat_frame_loader #(
        .NUM_FRAMES (NF),
        .FRAME_W    (FW),
        .FRAME_H    (FH)
    ) dut (
        .px_clk   (px_clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .fm_we    (fm_we),
        .fm_addr  (fm_addr),
        .fm_wdata (fm_wdata),
        .pm_we    (pm_we),
        .pm_addr  (pm_addr),
        .pm_wdata (pm_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        bit pal;
        int addr;
        int data;
        bit dn;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;
    int  fm_cnt, pm_cnt, done_cnt;
    int  first_fm_addr, first_fm_data, last_fm_addr, last_fm_data;
    int  last_pm_addr, last_pm_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input bit pal, input int addr, input int data, input bit dn);
        wr_t w;
        w.pal  = pal;
        w.addr = addr;
        w.data = data;
        w.dn   = dn;
        exp_q.push_back(w);
    endtask

    // Palette model: entry i takes the low six bits of the i-th payload byte
    task automatic expect_pal(input logic [7:0] b[16]);
        for (int i = 0; i < 16; i++) push_wr(1'b1, i, int'(b[i] & 8'h3F), i == 15);
    endtask

    // Frame model: byte k of frame f lands at f*W*H + 2k (high) and +1 (low)
    task automatic expect_frame_byte(input int f, input int k, input logic [7:0] b, input bit lo);
        push_wr(1'b0, f * FSZ + 2 * k, int'(b >> 4), 1'b0);
        if (lo) push_wr(1'b0, f * FSZ + 2 * k + 1, int'(b & 8'h0F), k == FB - 1);
    endtask

    task automatic clear_stats();
        fm_cnt = 0; pm_cnt = 0; done_cnt = 0;
        first_fm_addr = -1; first_fm_data = -1; last_fm_addr = -1; last_fm_data = -1;
        last_pm_addr = -1; last_pm_data = -1;
    endtask

    // Called and returning at 1 time unit after a rising edge
    task automatic send(input logic [7:0] b);
        int g = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && g < 50) begin
            @(posedge px_clk); #1;
            g++;
        end
        if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
        @(posedge px_clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge px_clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 20) begin
            @(posedge px_clk); #1;
            g++;
        end
        check(name, exp_q.size(), 0);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
    endtask

    // Per-cycle compare against the expected-write queue
    always @(negedge px_clk) begin
        if (mon_en) begin
            check("strobe_exclusive", 32'(fm_we && pm_we), 0);
            // Loader stalls exactly while a high nibble is being written
            check("s_ready_rule", 32'(s_ready), 32'(!(fm_we && !fm_addr[0])));
            if (fm_we || pm_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(fm_we || pm_we), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_kind", 32'(pm_we), 32'(e.pal));
                    if (e.pal) begin
                        check("pm_addr", 32'(pm_addr), e.addr);
                        check("pm_wdata", 32'(pm_wdata), e.data);
                    end else begin
                        check("fm_addr", 32'(fm_addr), e.addr);
                        check("fm_wdata", 32'(fm_wdata), e.data);
                    end
                    check("done_with_write", 32'(done), 32'(e.dn));
                end
                if (fm_we) begin
                    if (fm_cnt == 0) begin
                        first_fm_addr = int'(fm_addr);
                        first_fm_data = int'(fm_wdata);
                    end
                    fm_cnt++;
                    last_fm_addr = int'(fm_addr);
                    last_fm_data = int'(fm_wdata);
                end
                if (pm_we) begin
                    pm_cnt++;
                    last_pm_addr = int'(pm_addr);
                    last_pm_data = int'(pm_wdata);
                end
            end else begin
                check("done_idle", 32'(done), 0);
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pb[16];
        logic [7:0] b;

        clear_stats();
        repeat (3) @(posedge px_clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_fm_we", 32'(fm_we), 0);
        check("rst_pm_we", 32'(pm_we), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fm_addr", 32'(fm_addr), 0);
        check("rst_fm_wdata", 32'(fm_wdata), 0);
        check("rst_pm_addr", 32'(pm_addr), 0);
        check("rst_pm_wdata", 32'(pm_wdata), 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Palette load, bytes 0x00..0x0F back to back
        clear_stats();
        for (int i = 0; i < 16; i++) pb[i] = 8'(i);
        expect_pal(pb);
        send(8'hA5);
        check("cmd_busy", 32'(busy), 1);
        send(8'h01);
        for (int i = 0; i < 16; i++) send(pb[i]);
        drain("pal_drain");
        check("pal_count", pm_cnt, 16);
        check("pal_last_addr", last_pm_addr, 15);
        check("pal_last_data", last_pm_data, 32'h0F);
        check("pal_done_count", done_cnt, 1);

        // Frame 3, every byte 0x5A
        clear_stats();
        for (int k = 0; k < FB; k++) expect_frame_byte(3, k, 8'h5A, 1'b1);
        send(8'hA5); send(8'h02); send(8'h03);
        for (int k = 0; k < FB; k++) send(8'h5A);
        drain("f3_drain");
        check("f3_count", fm_cnt, 4096);
        check("f3_first_addr", first_fm_addr, 12288);
        check("f3_first_data", first_fm_data, 5);
        check("f3_last_addr", last_fm_addr, 16383);
        check("f3_last_data", last_fm_data, 32'hA);
        check("f3_done_count", done_cnt, 1);

        // Protocol errors and sticky err
        clear_stats();
        send(8'hA5); send(8'h07);
        check("badcmd_err", 32'(err), 1);
        check("badcmd_busy", 32'(busy), 0);
        idle(3);
        check("err_sticky", 32'(err), 1);
        send(8'hA5);
        check("resync_clears_err", 32'(err), 0);
        send(8'h02); send(8'h0C);
        check("badidx_err", 32'(err), 1);
        check("badidx_busy", 32'(busy), 0);
        idle(3);
        check("badidx_no_writes", fm_cnt, 0);
        for (int i = 0; i < 16; i++) pb[i] = 8'hC0 | 8'(i * 5);
        expect_pal(pb);
        send(8'hA5);
        check("err_cleared", 32'(err), 0);
        send(8'h01);
        for (int i = 0; i < 16; i++) send(pb[i]);
        drain("pal2_drain");
        check("pal2_count", pm_cnt, 16);
        check("pal2_last_data", last_pm_data, 32'h0B);

        // Frame 11 with random s_valid gaps
        clear_stats();
        for (int k = 0; k < FB; k++) expect_frame_byte(11, k, 8'(k * 37 + 11), 1'b1);
        send(8'hA5); send(8'h02); send(8'h0B);
        for (int k = 0; k < FB; k++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
            send(8'(k * 37 + 11));
        end
        drain("f11_drain");
        check("f11_count", fm_cnt, 4096);
        check("f11_first_addr", first_fm_addr, 45056);
        check("f11_last_addr", last_fm_addr, 49151);
        check("f11_done_count", done_cnt, 1);

        // Reset after 100 frame bytes; the 100th low nibble must not appear
        clear_stats();
        for (int k = 0; k < 100; k++) expect_frame_byte(0, k, 8'(k + 1), k < 99);
        send(8'hA5); send(8'h02); send(8'h00);
        for (int k = 0; k < 100; k++) send(8'(k + 1));
        reset = 1'b1;
        idle(1);
        check("mid_rst_fm_we", 32'(fm_we), 0);
        check("mid_rst_pm_we", 32'(pm_we), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_s_ready", 32'(s_ready), 1);
        check("mid_rst_fm_addr", 32'(fm_addr), 0);
        reset = 1'b0;
        idle(1);
        check("mid_rst_pending", exp_q.size(), 0);
        check("mid_rst_writes", fm_cnt, 199);
        clear_stats();
        for (int i = 0; i < 16; i++) pb[i] = 8'(63 - i);
        expect_pal(pb);
        send(8'hA5); send(8'h01);
        for (int i = 0; i < 16; i++) send(pb[i]);
        drain("pal3_drain");
        check("pal3_count", pm_cnt, 16);
        check("pal3_done_count", done_cnt, 1);

        // Noise before sync, and 0xA5 used as frame payload
        clear_stats();
        send(8'h00); send(8'hFF);
        idle(2);
        check("noise_no_writes", fm_cnt + pm_cnt, 0);
        check("noise_busy", 32'(busy), 0);
        for (int k = 0; k < FB; k++) begin
            b = (k % 3 == 0) ? 8'hA5 : 8'(k);
            expect_frame_byte(0, k, b, 1'b1);
        end
        send(8'hA5); send(8'h02); send(8'h00);
        for (int k = 0; k < FB; k++) begin
            b = (k % 3 == 0) ? 8'hA5 : 8'(k);
            send(b);
        end
        drain("f0_drain");
        check("f0_count", fm_cnt, 4096);
        check("f0_first_addr", first_fm_addr, 0);
        check("f0_first_data", first_fm_data, 32'hA);
        check("f0_last_addr", last_fm_addr, 4095);
        check("f0_done_count", done_cnt, 1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
